// File: rtl/tetrimino_generation.sv
// Falling-block game core: 10x20 board of 3-bit colours, one active piece,
// frame-paced moves and gravity, locking, row clearing and a saturating score.
module tetrimino_generation #(
    parameter int GRAVITY = 30
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [1:0]   operation,
    input  logic         vsync,
    input  logic [10:0]  framenumber,
    output logic [599:0] currentstate,
    output logic [7:0]   score,
    output logic         game_over
);

    typedef enum logic [2:0] {
        SPAWN = 3'd0,
        IDLE  = 3'd1,
        MOVE  = 3'd2,
        DROP  = 3'd3,
        LOCK  = 3'd4,
        CLEAR = 3'd5,
        OVER  = 3'd6
    } state_t;

    localparam int GW = (GRAVITY > 1) ? $clog2(GRAVITY) : 1;
    localparam logic [GW-1:0] GRAV_LAST = GW'(GRAVITY - 1);

    // 4x4 occupancy box of each piece type, bit index = row*4 + col.
    function automatic logic [15:0] shape_mask(input logic [2:0] kind);
        case (kind)
            3'd0:    return 16'h000F;
            3'd1:    return 16'h0066;
            3'd2:    return 16'h0027;
            3'd3:    return 16'h0036;
            3'd4:    return 16'h0063;
            3'd5:    return 16'h0047;
            3'd6:    return 16'h0017;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic piece_fits(input logic [599:0] board, input logic [2:0] kind,
                                        input logic signed [5:0] ox, input logic signed [5:0] oy);
        logic [15:0] m;
        logic        ok;
        int          cx;
        int          cy;
        m  = shape_mask(kind);
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cx = int'(ox) + (i % 4);
            cy = int'(oy) + (i / 4);
            if (m[i]) begin
                if (cx < 0 || cx > 9 || cy < 0 || cy > 19) begin
                    ok = 1'b0;
                end else if (board[(cy * 10 + cx) * 3 +: 3] != 3'd0) begin
                    ok = 1'b0;
                end else begin
                    ok = ok;
                end
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    state_t          state_r;
    logic [599:0]    board_r;
    logic [2:0]      kind_r;
    logic [3:0]      px_r;
    logic [4:0]      py_r;
    logic            active_r;
    logic [GW-1:0]   grav_r;
    logic [4:0]      row_r;
    logic [1:0]      op_r;
    logic            over_r;
    logic            vsync_d_r;
    logic [7:0]      score_r;

    logic            tick_s;
    logic [2:0]      spawn_kind_s;
    logic [2:0]      cand_kind_s;
    logic signed [5:0] cand_x_s;
    logic signed [5:0] cand_y_s;
    logic            cand_fits_s;
    logic            row_full_s;
    logic [15:0]     mask_s;
    logic [599:0]    overlay_s;

    assign tick_s       = vsync & ~vsync_d_r;
    assign spawn_kind_s = 3'(framenumber % 11'd7);

    // One legality checker shared by spawn, move and drop candidates.
    always_comb begin
        cand_kind_s = kind_r;
        cand_x_s    = $signed({2'b00, px_r});
        cand_y_s    = $signed({1'b0, py_r});
        case (state_r)
            SPAWN: begin
                cand_kind_s = spawn_kind_s;
                cand_x_s    = 6'sd3;
                cand_y_s    = 6'sd0;
            end
            MOVE: begin
                if (op_r == 2'b01) begin
                    cand_x_s = $signed({2'b00, px_r}) + 6'sd1;
                end else if (op_r == 2'b10) begin
                    cand_x_s = $signed({2'b00, px_r}) - 6'sd1;
                end else begin
                    cand_x_s = $signed({2'b00, px_r});
                end
            end
            DROP:    cand_y_s = $signed({1'b0, py_r}) + 6'sd1;
            default: cand_kind_s = kind_r;
        endcase
        cand_fits_s = piece_fits(board_r, cand_kind_s, cand_x_s, cand_y_s);
    end

    // Full-row detect on the row currently under the clear pointer.
    always_comb begin
        row_full_s = 1'b1;
        for (int x = 0; x < 10; x++) begin
            row_full_s = row_full_s & (board_r[(int'(row_r) * 10 + x) * 3 +: 3] != 3'd0);
        end
    end

    // Settled board with the active piece painted on top.
    always_comb begin
        mask_s    = shape_mask(kind_r);
        overlay_s = board_r;
        for (int c = 0; c < 200; c++) begin
            int         dx;
            int         dy;
            logic [3:0] bi;
            dx = (c % 10) - int'(px_r);
            dy = (c / 10) - int'(py_r);
            bi = 4'(dy * 4 + dx);
            if (active_r && dx >= 0 && dx < 4 && dy >= 0 && dy < 4 && mask_s[bi]) begin
                overlay_s[c * 3 +: 3] = kind_r + 3'd1;
            end else begin
                overlay_s[c * 3 +: 3] = board_r[c * 3 +: 3];
            end
        end
    end

    // Game sequencer: spawn, per-tick move/gravity, lock and row clearing.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= SPAWN;
            board_r   <= 600'd0;
            kind_r    <= 3'd0;
            px_r      <= 4'd0;
            py_r      <= 5'd0;
            active_r  <= 1'b0;
            grav_r    <= GW'(0);
            row_r     <= 5'd19;
            op_r      <= 2'd0;
            over_r    <= 1'b0;
            vsync_d_r <= 1'b0;
        end else begin
            vsync_d_r <= vsync;
            case (state_r)
                SPAWN: begin
                    kind_r <= spawn_kind_s;
                    px_r   <= 4'd3;
                    py_r   <= 5'd0;
                    grav_r <= GW'(0);
                    if (cand_fits_s) begin
                        active_r <= 1'b1;
                        state_r  <= IDLE;
                    end else begin
                        active_r <= 1'b0;
                        over_r   <= 1'b1;
                        state_r  <= OVER;
                    end
                end
                IDLE: begin
                    if (tick_s) begin
                        op_r    <= operation;
                        state_r <= MOVE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MOVE: begin
                    if (cand_fits_s) begin
                        px_r <= cand_x_s[3:0];
                    end else begin
                        px_r <= px_r;
                    end
                    state_r <= DROP;
                end
                DROP: begin
                    if (grav_r == GRAV_LAST) begin
                        grav_r <= GW'(0);
                        if (cand_fits_s) begin
                            py_r    <= cand_y_s[4:0];
                            state_r <= IDLE;
                        end else begin
                            state_r <= LOCK;
                        end
                    end else begin
                        grav_r  <= grav_r + GW'(1);
                        state_r <= IDLE;
                    end
                end
                LOCK: begin
                    board_r  <= overlay_s;
                    active_r <= 1'b0;
                    row_r    <= 5'd19;
                    state_r  <= CLEAR;
                end
                CLEAR: begin
                    if (row_full_s) begin
                        // Rows above the pointer fall by one; the pointer stays to re-test.
                        for (int y = 0; y < 20; y++) begin
                            if (y == 0) begin
                                board_r[0 +: 30] <= 30'd0;
                            end else if (y <= int'(row_r)) begin
                                board_r[y * 30 +: 30] <= board_r[(y - 1) * 30 +: 30];
                            end else begin
                                board_r[y * 30 +: 30] <= board_r[y * 30 +: 30];
                            end
                        end
                    end else if (row_r == 5'd0) begin
                        state_r <= SPAWN;
                    end else begin
                        row_r <= row_r - 5'd1;
                    end
                end
                OVER:    state_r <= OVER;
                default: state_r <= SPAWN;
            endcase
        end
    end

    // Cleared-row counter, saturating at 255.
    always_ff @(posedge clock) begin
        if (reset) begin
            score_r <= 8'd0;
        end else if (state_r == CLEAR && row_full_s && score_r != 8'd255) begin
            score_r <= score_r + 8'd1;
        end else begin
            score_r <= score_r;
        end
    end

    assign currentstate = overlay_s;
    assign score        = score_r;
    assign game_over    = over_r;

endmodule

// File: tb/tb_tetrimino_generation.sv
// Self-checking bench: per-tick comparison against a board-level game model.
module tb_tetrimino_generation;

    localparam int G = 1;

    logic         clock = 1'b0;
    logic         reset;
    logic [1:0]   operation;
    logic         vsync;
    logic [10:0]  framenumber;
    logic [599:0] currentstate;
    logic [7:0]   score;
    logic         game_over;

    int total = 0;
    int bad   = 0;

    tetrimino_generation #(.GRAVITY(G)) dut (
        .clock       (clock),
        .reset       (reset),
        .operation   (operation),
        .vsync       (vsync),
        .framenumber (framenumber),
        .currentstate(currentstate),
        .score       (score),
        .game_over   (game_over)
    );

    always #5 clock = ~clock;

    // Reference model: board as colour grid, piece as type + origin.
    int sh_c [7][4] = '{'{0,1,2,3}, '{1,2,1,2}, '{0,1,2,1}, '{1,2,0,1},
                        '{0,1,1,2}, '{0,1,2,2}, '{0,1,2,0}};
    int sh_r [7][4] = '{'{0,0,0,0}, '{0,0,1,1}, '{0,0,0,1}, '{0,0,1,1},
                        '{0,0,1,1}, '{0,0,0,1}, '{0,0,0,1}};
    int mb [20][10];
    int m_kind, m_px, m_py, m_gc, m_score;
    bit m_active, m_over;

    function automatic bit m_fits(int k, int x, int y);
        for (int i = 0; i < 4; i++) begin
            int cx = x + sh_c[k][i];
            int cy = y + sh_r[k][i];
            if (cx < 0 || cx > 9 || cy < 0 || cy > 19) return 1'b0;
            if (mb[cy][cx] != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic m_spawn(int fn);
        m_kind = fn % 7;
        m_px   = 3;
        m_py   = 0;
        m_gc   = 0;
        if (m_fits(m_kind, m_px, m_py)) m_active = 1'b1;
        else begin
            m_active = 1'b0;
            m_over   = 1'b1;
        end
    endtask

    task automatic m_reset(int fn);
        foreach (mb[y, x]) mb[y][x] = 0;
        m_score  = 0;
        m_over   = 1'b0;
        m_active = 1'b0;
        m_spawn(fn);
    endtask

    task automatic m_lock_clear(int fn);
        int nb [20][10];
        int dst;
        for (int i = 0; i < 4; i++) mb[m_py + sh_r[m_kind][i]][m_px + sh_c[m_kind][i]] = m_kind + 1;
        m_active = 1'b0;
        foreach (nb[y, x]) nb[y][x] = 0;
        dst = 19;
        for (int y = 19; y >= 0; y--) begin
            bit full = 1'b1;
            for (int x = 0; x < 10; x++) if (mb[y][x] == 0) full = 1'b0;
            if (full) begin
                if (m_score < 255) m_score++;
            end else begin
                for (int x = 0; x < 10; x++) nb[dst][x] = mb[y][x];
                dst--;
            end
        end
        mb = nb;
        m_spawn(fn);
    endtask

    task automatic m_tick(int op, int fn);
        if (m_over) return;
        if (op == 1 && m_fits(m_kind, m_px + 1, m_py)) m_px++;
        else if (op == 2 && m_fits(m_kind, m_px - 1, m_py)) m_px--;
        m_gc++;
        if (m_gc == G) begin
            m_gc = 0;
            if (m_fits(m_kind, m_px, m_py + 1)) m_py++;
            else m_lock_clear(fn);
        end
    endtask

    function automatic logic [599:0] m_view();
        logic [599:0] v = '0;
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++) v[(y * 10 + x) * 3 +: 3] = 3'(mb[y][x]);
        if (m_active)
            for (int i = 0; i < 4; i++)
                v[((m_py + sh_r[m_kind][i]) * 10 + m_px + sh_c[m_kind][i]) * 3 +: 3] = 3'(m_kind + 1);
        return v;
    endfunction

    task automatic check_all(input string tag);
        logic [599:0] ev;
        ev = m_view();
        total++;
        assert (currentstate === ev) else begin
            bad++;
            $error("FAIL %s board: observed %h expected %h", tag, currentstate, ev);
        end
        total++;
        assert (score === 8'(m_score)) else begin
            bad++;
            $error("FAIL %s score: observed %0d expected %0d", tag, score, m_score);
        end
        total++;
        assert (game_over === m_over) else begin
            bad++;
            $error("FAIL %s game_over: observed %0b expected %0b", tag, game_over, m_over);
        end
    endtask

    task automatic do_reset(input logic [10:0] fn);
        framenumber = fn;
        operation   = 2'b00;
        vsync       = 1'b0;
        reset       = 1'b1;
        @(negedge clock);
        total++;
        assert (currentstate === 600'd0 && score === 8'd0 && game_over === 1'b0) else begin
            bad++;
            $error("FAIL reset_values: observed score=%0d over=%0b board=%h", score, game_over, currentstate);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        m_reset(int'(fn));
        check_all("after_reset");
    endtask

    task automatic do_tick(input logic [1:0] op, input logic [10:0] fn, input string tag);
        operation   = op;
        framenumber = fn;
        @(negedge clock);
        vsync = 1'b1;
        repeat (3) @(negedge clock);
        vsync = 1'b0;
        repeat (40) @(negedge clock);
        m_tick(int'(op), int'(fn));
        check_all(tag);
    endtask

    // I left x3, I right x1, O right x4: completes row 19.
    task automatic build_row();
        for (int i = 0; i < 20; i++) do_tick((i < 3) ? 2'b10 : 2'b00, 11'd0, "row_p1");
        for (int i = 0; i < 20; i++) do_tick((i < 1) ? 2'b01 : 2'b00, (i == 19) ? 11'd1 : 11'd0, "row_p2");
        for (int i = 0; i < 19; i++) do_tick((i < 4) ? 2'b01 : 2'b00, 11'd0, "row_p3");
    endtask

    initial begin
        logic [599:0] ev;
        logic [29:0]  r19;

        // Reset shows the I piece at row 0, cols 3-6.
        do_reset(11'd0);
        ev = '0;
        for (int x = 3; x <= 6; x++) ev[x * 3 +: 3] = 3'd1;
        total++;
        assert (currentstate === ev) else begin
            bad++;
            $error("FAIL first_spawn: observed %h expected %h", currentstate, ev);
        end

        // Right held: stops at cols 6-9, then both bits do nothing.
        for (int i = 0; i < 8; i++) do_tick(2'b01, 11'd0, "right_hold");
        ev = '0;
        for (int x = 6; x <= 9; x++) ev[(80 + x) * 3 +: 3] = 3'd1;
        total++;
        assert (currentstate === ev) else begin
            bad++;
            $error("FAIL right_wall: observed %h expected %h", currentstate, ev);
        end
        for (int i = 0; i < 2; i++) do_tick(2'b01, 11'd0, "right_wall_more");
        do_tick(2'b11, 11'd0, "both_bits");

        // Free fall to row 19, then lock and spawn a T.
        do_reset(11'd0);
        for (int i = 0; i < 19; i++) do_tick(2'b00, 11'd0, "fall");
        ev = '0;
        for (int x = 3; x <= 6; x++) ev[(190 + x) * 3 +: 3] = 3'd1;
        total++;
        assert (currentstate === ev) else begin
            bad++;
            $error("FAIL at_row19: observed %h expected %h", currentstate, ev);
        end
        do_tick(2'b00, 11'd2, "lock_then_T");

        // Row completion and clear.
        do_reset(11'd0);
        build_row();
        r19 = 30'd0;
        r19[24 +: 3] = 3'd2;
        r19[27 +: 3] = 3'd2;
        total++;
        assert (currentstate[570 +: 30] === r19 && score === 8'd1) else begin
            bad++;
            $error("FAIL row_clear: observed row19=%h score=%0d expected row19=%h score=1",
                   currentstate[570 +: 30], score, r19);
        end

        // Score saturation from a preset 255.
        do_reset(11'd0);
        force dut.score_r = 8'd255;
        repeat (2) @(negedge clock);
        release dut.score_r;
        @(negedge clock);
        m_score = 255;
        check_all("preset_255");
        build_row();
        total++;
        assert (score === 8'd255) else begin
            bad++;
            $error("FAIL score_saturate: observed %0d expected 255", score);
        end

        // Stack O pieces until spawn is blocked.
        do_reset(11'd1);
        for (int i = 0; i < 150 && !m_over; i++) do_tick(2'b00, 11'd1, "o_stack");
        total++;
        assert (game_over === 1'b1) else begin
            bad++;
            $error("FAIL game_over_set: observed %0b expected 1", game_over);
        end
        for (int i = 0; i < 3; i++) do_tick(2'(i + 1), 11'(i), "over_frozen");
        do_reset(11'd1);

        // Random play against the model.
        do_reset(11'($urandom_range(0, 2047)));
        for (int i = 0; i < 150; i++) begin
            if (m_over) do_reset(11'($urandom_range(0, 2047)));
            do_tick(2'($urandom_range(0, 3)), 11'($urandom_range(0, 2047)), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
